// File: rtl/operand_fifo_pkg.sv
// Shared defaults and pair type for the operand FIFO ahead of the equality comparator.
// No logic here; widths only.
package operand_fifo_pkg;

  localparam int OPF_DATA_W = 2;
  localparam int OPF_DEPTH  = 4;

  typedef struct packed {
    logic [OPF_DATA_W-1:0] a;
    logic [OPF_DATA_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/pair_fifo_mem.sv
// Pair storage array: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on the next cycle, read combinational; no backpressure at this level.
module pair_fifo_mem
  import operand_fifo_pkg::*;
#(
  parameter int WIDTH  = 2 * OPF_DATA_W,
  parameter int DEPTH  = OPF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/operand_pair_fifo.sv
// FWFT FIFO of (A,B) operand pairs feeding the equality comparator; head visible with zero added latency.
// Backpressure: wr_ready=!full, rd_valid=!empty, both from registered state only (no cross-side comb path).
module operand_pair_fifo
  import operand_fifo_pkg::*;
#(
  parameter int DATA_W = OPF_DATA_W,
  parameter int DEPTH  = OPF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [ADDR_W:0]   count
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q,  count_d;

  logic                  empty, full, push, pop;
  logic [2*DATA_W-1:0]   wdata, rdata;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign push = wr_valid && !full;
  assign pop  = rd_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop) begin
        count_d = count_q + PTR_ONE;
      end else if (pop && !push) begin
        count_d = count_q - PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata = {wr_a, wr_b};

  pair_fifo_mem #(
    .WIDTH  (2 * DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Mask the head when empty so the comparator never sees stale entries.
  assign rd_a     = empty ? '0 : rdata[2*DATA_W-1:DATA_W];
  assign rd_b     = empty ? '0 : rdata[DATA_W-1:0];
  assign rd_valid = !empty;
  assign wr_ready = !full;
  assign count    = count_q;

endmodule

// File: tb/tb_operand_pair_fifo.sv
// Directed bench for operand_pair_fifo: reset, fill/overflow, drain order, streaming wrap, flush, async reset.
module tb_operand_pair_fifo;
  import operand_fifo_pkg::*;

  localparam int DW = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_a, wr_b;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_a, rd_b;
  logic [AW:0]   count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  operand_pair_fifo #(.DATA_W(DW), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_a     (wr_a),
    .wr_b     (wr_b),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .count    (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_a = '0; wr_b = '0;
    #12;
    rst_n = 1'b1;
    tick(); tick();
    tests_run++;
    if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++;
    if ({rd_a, rd_b} !== 4'h0) begin tests_failed++; $display("FAIL reset_rd_data: got a=%0d b=%0d want 0,0", rd_a, rd_b); end
  endtask

  task automatic test_fill();
    logic [3:0] pairs [4];
    pairs[0] = 4'b01_01; pairs[1] = 4'b10_11; pairs[2] = 4'b11_00; pairs[3] = 4'b00_00;
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      {wr_a, wr_b} = pairs[i];
      tick();
    end
    tests_run++;
    if (count !== 3'd4) begin tests_failed++; $display("FAIL fill_count: got %0d want 4", count); end
    tests_run++;
    if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
    wr_a = 2'd2; wr_b = 2'd2;
    tick();
    wr_valid = 1'b0;
    tests_run++;
    if (count !== 3'd4) begin tests_failed++; $display("FAIL overflow_count: got %0d want 4", count); end
    tests_run++;
    if ({rd_a, rd_b} !== 4'b01_01) begin tests_failed++; $display("FAIL overflow_head: got a=%0d b=%0d want 1,1", rd_a, rd_b); end
  endtask

  task automatic test_drain();
    logic [3:0] pairs [4];
    pairs[0] = 4'b01_01; pairs[1] = 4'b10_11; pairs[2] = 4'b11_00; pairs[3] = 4'b00_00;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_valid !== 1'b1 || {rd_a, rd_b} !== pairs[i]) begin
        tests_failed++;
        $display("FAIL drain_pair%0d: got v=%b a=%0d b=%0d want v=1 a=%0d b=%0d", i, rd_valid, rd_a, rd_b, pairs[i][3:2], pairs[i][1:0]);
      end
      tick();
    end
    rd_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL drain_count: got %0d want 0", count); end
    tests_run++;
    if (rd_valid !== 1'b0 || {rd_a, rd_b} !== 4'h0) begin
      tests_failed++; $display("FAIL drain_empty: got v=%b a=%0d b=%0d want v=0 a=0 b=0", rd_valid, rd_a, rd_b);
    end
  endtask

  task automatic test_stream();
    pair_t exp_p;
    logic  exp_c, obs_c;
    int    prev;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        prev    = (i - 1) % 16;
        exp_p.a = 2'(prev >> 2);
        exp_p.b = 2'(prev & 3);
        exp_c   = (exp_p.a == exp_p.b);
        obs_c   = rd_valid && (rd_a == rd_b);
        tests_run++;
        if (rd_valid !== 1'b1 || {rd_a, rd_b} !== exp_p) begin
          tests_failed++; $display("FAIL stream_pair%0d: got v=%b a=%0d b=%0d want a=%0d b=%0d", i, rd_valid, rd_a, rd_b, exp_p.a, exp_p.b);
        end
        tests_run++;
        if (obs_c !== exp_c) begin tests_failed++; $display("FAIL stream_cmp%0d: got c=%b want %b", i, obs_c, exp_c); end
        tests_run++;
        if (count !== 3'd1) begin tests_failed++; $display("FAIL stream_count%0d: got %0d want 1", i, count); end
      end
      wr_a = 2'((i % 16) >> 2);
      wr_b = 2'((i % 16) & 3);
      tick();
    end
    wr_valid = 1'b0;
    tests_run++;
    if ({rd_a, rd_b} !== 4'b00_11) begin tests_failed++; $display("FAIL stream_last: got a=%0d b=%0d want 0,3", rd_a, rd_b); end
    tick();
    rd_ready = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL stream_end: got v=%b count=%0d want v=0 count=0", rd_valid, count);
    end
  endtask

  task automatic test_flush();
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_a = 2'(i + 1);
      wr_b = 2'(i);
      tick();
    end
    tests_run++;
    if (count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    flush = 1'b1; wr_a = 2'd3; wr_b = 2'd3; rd_ready = 1'b1;
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_state: got count=%0d v=%b rdy=%b want 0,0,1", count, rd_valid, wr_ready);
    end
    wr_valid = 1'b1; wr_a = 2'd1; wr_b = 2'd2;
    tick();
    wr_valid = 1'b0;
    tests_run++;
    if (count !== 3'd1 || {rd_a, rd_b} !== 4'b01_10) begin
      tests_failed++; $display("FAIL flush_after: got count=%0d a=%0d b=%0d want 1,1,2", count, rd_a, rd_b);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    wr_valid = 1'b1;
    wr_a = 2'd2; wr_b = 2'd1; tick();
    wr_a = 2'd1; wr_b = 2'd3; tick();
    wr_valid = 1'b0;
    tests_run++;
    if (count !== 3'd2) begin tests_failed++; $display("FAIL arst_pre_count: got %0d want 2", count); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 || {rd_a, rd_b} !== 4'h0) begin
      tests_failed++;
      $display("FAIL arst_immediate: got count=%0d v=%b rdy=%b a=%0d b=%0d want 0,0,1,0,0", count, rd_valid, wr_ready, rd_a, rd_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr_valid = 1'b1; wr_a = 2'd3; wr_b = 2'd3;
    tick();
    wr_valid = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || {rd_a, rd_b} !== 4'b11_11 || count !== 3'd1) begin
      tests_failed++; $display("FAIL arst_first_pair: got v=%b a=%0d b=%0d count=%0d want 1,3,3,1", rd_valid, rd_a, rd_b, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
